// File: rtl/led_pwm_pkg.sv
// Shared types, register offsets and parameter limits for the LED PWM controller.
package led_pwm_pkg;

    // Legal parameter ranges
    localparam int unsigned MinNumLeds = 1;
    localparam int unsigned MaxNumLeds = 16;
    localparam int unsigned MinPwmBits = 2;
    localparam int unsigned MaxPwmBits = 16;

    // Width of the PRESCALE / BLINK_HALF registers and their counters
    localparam int unsigned TimerW = 16;

    // Byte offsets within the register window (only addr[7:2] is decoded)
    localparam logic [7:0] OffMode      = 8'h00;
    localparam logic [7:0] OffPrescale  = 8'h04;
    localparam logic [7:0] OffBlinkHalf = 8'h08;
    localparam logic [7:0] OffStatus    = 8'h0C;
    localparam logic [7:0] OffDutyBase  = 8'h40;

    typedef enum logic [1:0] {
        ModeOff   = 2'b00,
        ModeOn    = 2'b01,
        ModePwm   = 2'b10,
        ModeBlink = 2'b11
    } led_mode_e;

    // Next LED level for one channel given its mode and the shared timing state
    function automatic logic led_next(input led_mode_e mode, input logic level,
                                      input logic phase);
        logic led;
        case (mode)
            ModeOff:   led = 1'b0;
            ModeOn:    led = 1'b1;
            ModePwm:   led = level;
            ModeBlink: led = level & phase;
            default:   led = 1'b0;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// 32-bit Wishbone classic bus bundle with master and slave views.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        stall;
    logic        rty;

    modport MASTER (
        output cyc, stb, we, addr, wdata,
        input  rdata, ack, err, stall, rty
    );

    modport SLAVE (
        input  cyc, stb, we, addr, wdata,
        output rdata, ack, err, stall, rty
    );
endinterface

// File: rtl/led_pwm_timebase.sv
// Shared timebase: prescaler tick, PWM counter, period boundary and blink phase.
module led_pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [TimerW-1:0]   i_prescale,
    input  logic [TimerW-1:0]   i_blink_half,
    input  logic                i_clr_pwm,
    input  logic                i_clr_blink,
    output logic [PWM_BITS-1:0] o_pwm_cnt,
    output logic                o_boundary,
    output logic                o_blink_phase
);

    logic [TimerW-1:0]   r_pre_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [TimerW-1:0]   r_blink_cnt;
    logic                r_blink_phase;

    logic w_tick;
    logic w_boundary;

    assign w_tick = (r_pre_cnt == i_prescale);
    // A counter clear is not a wrap, so it never produces a boundary
    assign w_boundary = w_tick && (r_pwm_cnt == '1) && !i_clr_pwm;

    // Prescaler and PWM counter; a PRESCALE write restarts both
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (i_clr_pwm) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end else begin
            r_pre_cnt <= r_pre_cnt + TimerW'(1);
        end
    end

    // Blink counter counts period boundaries and flips the phase every BLINK_HALF+1 of them
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (i_clr_blink) begin
            r_blink_cnt <= '0;
        end else if (w_boundary) begin
            if (r_blink_cnt == i_blink_half) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + TimerW'(1);
            end
        end
    end

    assign o_pwm_cnt     = r_pwm_cnt;
    assign o_boundary    = w_boundary;
    assign o_blink_phase = r_blink_phase;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver (off/on/PWM/blink) with a Wishbone register interface.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    wishbone_if.SLAVE           wb_if,
    output logic [NUM_LEDS-1:0] led_o
);

    localparam int unsigned ModeW = 2 * NUM_LEDS;

    if (NUM_LEDS < MinNumLeds || NUM_LEDS > MaxNumLeds) begin : gen_bad_num_leds
        $error("led_pwm_ctrl: NUM_LEDS out of range");
    end
    if (PWM_BITS < MinPwmBits || PWM_BITS > MaxPwmBits) begin : gen_bad_pwm_bits
        $error("led_pwm_ctrl: PWM_BITS out of range");
    end

    // Registers
    logic [ModeW-1:0]    r_mode;
    logic [TimerW-1:0]   r_prescale;
    logic [TimerW-1:0]   r_blink_half;
    logic [PWM_BITS-1:0] r_duty_shadow [NUM_LEDS];
    logic [PWM_BITS-1:0] r_duty_active [NUM_LEDS];
    logic [NUM_LEDS-1:0] r_led;
    logic                r_ack;
    logic                r_err;
    logic [31:0]         r_rdata;

    // Decode and datapath wires
    logic                w_req;
    logic                w_wr;
    logic [5:0]          w_word;
    logic [5:0]          w_duty_off;
    logic                w_sel_mode;
    logic                w_sel_prescale;
    logic                w_sel_blink;
    logic                w_sel_status;
    logic                w_sel_duty;
    logic                w_mapped;
    logic                w_wr_prescale;
    logic                w_wr_blink;
    logic [NUM_LEDS-1:0] w_duty_we;
    logic [31:0]         w_rdata;
    logic [NUM_LEDS-1:0] w_level;
    logic [NUM_LEDS-1:0] w_led_d;
    logic [PWM_BITS-1:0] w_pwm_cnt;
    logic                w_boundary;
    logic                w_blink_phase;
    logic                w_unused;

    assign w_req  = wb_if.cyc & wb_if.stb;
    assign w_wr   = w_req & wb_if.we;
    assign w_word = wb_if.addr[7:2];

    assign w_sel_mode     = (w_word == OffMode[7:2]);
    assign w_sel_prescale = (w_word == OffPrescale[7:2]);
    assign w_sel_blink    = (w_word == OffBlinkHalf[7:2]);
    assign w_sel_status   = (w_word == OffStatus[7:2]);
    assign w_duty_off     = w_word - OffDutyBase[7:2];
    // Duty slots beyond the instantiated channels are unmapped
    assign w_sel_duty     = (w_word >= OffDutyBase[7:2]) && (w_duty_off < 6'(NUM_LEDS));
    assign w_mapped       = w_sel_mode | w_sel_prescale | w_sel_blink | w_sel_status | w_sel_duty;

    assign w_wr_prescale = w_wr & w_sel_prescale;
    assign w_wr_blink    = w_wr & w_sel_blink;

    // Per-channel duty write strobes
    always_comb begin
        w_duty_we = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_duty_we[i] = w_wr & w_sel_duty & (w_duty_off == 6'(i));
        end
    end

    // Read mux, zero-extended; unmapped offsets read 0
    always_comb begin
        w_rdata = '0;
        if (w_sel_mode) begin
            w_rdata = 32'(r_mode);
        end else if (w_sel_prescale) begin
            w_rdata = 32'(r_prescale);
        end else if (w_sel_blink) begin
            w_rdata = 32'(r_blink_half);
        end else if (w_sel_status) begin
            w_rdata = 32'(r_led);
        end else if (w_sel_duty) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_duty_off == 6'(i)) begin
                    w_rdata = 32'(r_duty_shadow[i]);
                end
            end
        end
    end

    // Single-cycle registered response; reset drops any request in flight
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_req & w_mapped;
            r_err   <= w_req & ~w_mapped;
            r_rdata <= (w_req & ~wb_if.we) ? w_rdata : '0;
        end
    end

    // Control registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mode       <= '0;
            r_prescale   <= '0;
            r_blink_half <= '0;
        end else if (w_wr) begin
            if (w_sel_mode)     r_mode       <= wb_if.wdata[ModeW-1:0];
            if (w_sel_prescale) r_prescale   <= wb_if.wdata[TimerW-1:0];
            if (w_sel_blink)    r_blink_half <= wb_if.wdata[TimerW-1:0];
        end
    end

    // Shadow duties take bus writes at any time
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_LEDS; i++) r_duty_shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_duty_we[i]) r_duty_shadow[i] <= wb_if.wdata[PWM_BITS-1:0];
            end
        end
    end

    // Active duties follow the shadows only on a period boundary (pre-write shadow value)
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_LEDS; i++) r_duty_active[i] <= '0;
        end else if (w_boundary) begin
            for (int i = 0; i < NUM_LEDS; i++) r_duty_active[i] <= r_duty_shadow[i];
        end
    end

    led_pwm_timebase #(
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .i_prescale    (r_prescale),
        .i_blink_half  (r_blink_half),
        .i_clr_pwm     (w_wr_prescale),
        .i_clr_blink   (w_wr_blink),
        .o_pwm_cnt     (w_pwm_cnt),
        .o_boundary    (w_boundary),
        .o_blink_phase (w_blink_phase)
    );

    // Next LED levels from mode, PWM comparison and blink phase
    always_comb begin
        w_level = '0;
        w_led_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_level[i] = (w_pwm_cnt < r_duty_active[i]);
            w_led_d[i] = led_next(led_mode_e'(r_mode[2*i +: 2]), w_level[i], w_blink_phase);
        end
    end

    // Registered LED drive
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_d;
        end
    end

    assign led_o       = r_led;
    assign wb_if.ack   = r_ack;
    assign wb_if.err   = r_err;
    assign wb_if.rdata = r_rdata;
    assign wb_if.stall = 1'b0;
    assign wb_if.rty   = 1'b0;

    assign w_unused = ^{wb_if.addr[31:8], wb_if.addr[1:0], wb_if.wdata};

endmodule
